adc_scan_sched: RTL and testbench

//  Scheduler for the six-channel ADS7883 readout sequencer. Issues conversion

---
 rtl/adc_scan_sched.sv | 219 +++++++++++++++++++++
 tb/tb_adc_scan_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sched.sv
// Conversion scheduler and box-car averager for the six-channel ADS7883 sequencer.
// Define ADC_SCAN_SCHED_ALARM_EN to build the per-channel over-threshold alarms.
module adc_scan_sched #(
    parameter int NCH      = 6,
    parameter int AVG_LOG2 = 3,
    parameter int TMO      = 255
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                reg_we_i,
    input  logic [7:0]          reg_addr_i,
    input  logic [15:0]         reg_data_i,
    output logic [15:0]         reg_data_o,
    output logic                conv_start_o,
    input  logic                conv_done_i,
    input  logic [NCH*12-1:0]   adc_data_i,
    output logic [NCH*12-1:0]   avg_data_o,
    output logic                avg_valid_o,
    output logic [NCH-1:0]      alarm_o
);

    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TMO + 1);
    localparam logic [CW-1:0] NAVG = CW'(2 ** AVG_LOG2);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_BUSY, S_ACC, S_LAT} state_t;

    state_t             state_q, state_d;
    logic               ctrl_en_q, ss_q, oneshot_q;
    logic [15:0]        period_q, per_cnt_q;
    logic [TW-1:0]      tmo_cnt_q;
    logic [CW-1:0]      cnt_q, cnt_inc;
    logic [AW-1:0]      acc_q [NCH];
    logic [NCH*12-1:0]  smp_q, avg_q;
    logic               avg_valid_q, timeout_q, overrun_q;
    logic               run;
    logic               load_per, load_tmo, capture, acc_add, acc_clr, latch;
    logic               set_tmo, go_oneshot, end_oneshot;

    assign run     = ctrl_en_q | oneshot_q;
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // A scan that loses its enable is abandoned at the next WAIT or ACC, never mid-conversion.
    always_comb begin
        state_d      = state_q;
        conv_start_o = 1'b0;
        load_per     = 1'b0;
        load_tmo     = 1'b0;
        capture      = 1'b0;
        acc_add      = 1'b0;
        acc_clr      = 1'b0;
        latch        = 1'b0;
        set_tmo      = 1'b0;
        go_oneshot   = 1'b0;
        end_oneshot  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_en_q || ss_q) begin
                    go_oneshot = !ctrl_en_q;
                    load_per   = 1'b1;
                    state_d    = (period_q == 16'd0) ? S_START : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!run) begin
                    acc_clr = 1'b1;
                    state_d = S_IDLE;
                end else if (per_cnt_q == 16'd0) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                conv_start_o = 1'b1;
                load_tmo     = 1'b1;
                state_d      = S_BUSY;
            end
            S_BUSY: begin
                if (conv_done_i) begin
                    capture = 1'b1;
                    state_d = S_ACC;
                end else if (tmo_cnt_q == '0) begin
                    set_tmo     = 1'b1;
                    acc_clr     = 1'b1;
                    end_oneshot = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_ACC: begin
                if (!run) begin
                    acc_clr = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    acc_add = 1'b1;
                    if (cnt_inc == NAVG) begin
                        state_d = S_LAT;
                    end else begin
                        load_per = 1'b1;
                        state_d  = (period_q == 16'd0) ? S_START : S_WAIT;
                    end
                end
            end
            S_LAT: begin
                latch       = 1'b1;
                acc_clr     = 1'b1;
                end_oneshot = 1'b1;
                if (ctrl_en_q) begin
                    load_per = 1'b1;
                    state_d  = (period_q == 16'd0) ? S_START : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_en_q   <= 1'b0;
            ss_q        <= 1'b0;
            oneshot_q   <= 1'b0;
            period_q    <= '0;
            per_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            cnt_q       <= '0;
            smp_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
        end else begin
            ss_q <= reg_we_i && (reg_addr_i == 8'h10) && reg_data_i[1];
            if (reg_we_i && reg_addr_i == 8'h10) ctrl_en_q <= reg_data_i[0];
            if (reg_we_i && reg_addr_i == 8'h11) period_q  <= reg_data_i;

            if (go_oneshot)       oneshot_q <= 1'b1;
            else if (end_oneshot) oneshot_q <= 1'b0;

            if (load_per)                                   per_cnt_q <= period_q - 16'd1;
            else if (state_q == S_WAIT && per_cnt_q != '0)  per_cnt_q <= per_cnt_q - 16'd1;

            if (load_tmo)                                   tmo_cnt_q <= TW'(TMO - 1);
            else if (state_q == S_BUSY && tmo_cnt_q != '0)  tmo_cnt_q <= tmo_cnt_q - TW'(1);

            if (capture) smp_q <= adc_data_i;

            if (acc_clr) begin
                cnt_q <= '0;
                for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
            end else if (acc_add) begin
                cnt_q <= cnt_inc;
                for (int c = 0; c < NCH; c++) acc_q[c] <= acc_q[c] + AW'(smp_q[c*12 +: 12]);
            end

            if (latch)
                for (int c = 0; c < NCH; c++) avg_q[c*12 +: 12] <= acc_q[c][AVG_LOG2 +: 12];
            avg_valid_q <= latch;

            // Sticky flags: a set in the same cycle as a W1C write wins.
            if (set_tmo)                                             timeout_q <= 1'b1;
            else if (reg_we_i && reg_addr_i == 8'h12 && reg_data_i[1]) timeout_q <= 1'b0;
            if (conv_done_i && state_q != S_BUSY)                      overrun_q <= 1'b1;
            else if (reg_we_i && reg_addr_i == 8'h12 && reg_data_i[2]) overrun_q <= 1'b0;
        end
    end

`ifdef ADC_SCAN_SCHED_ALARM_EN
    logic [11:0]    thr_q;
    logic [NCH-1:0] alarm_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            thr_q   <= 12'hFFF;
            alarm_q <= '0;
        end else begin
            if (reg_we_i && reg_addr_i == 8'h19) thr_q <= reg_data_i[11:0];
            for (int c = 0; c < NCH; c++) begin
                if (latch && acc_q[c][AVG_LOG2 +: 12] > thr_q)        alarm_q[c] <= 1'b1;
                else if (reg_we_i && reg_addr_i == 8'h1A && reg_data_i[c]) alarm_q[c] <= 1'b0;
            end
        end
    end

    assign alarm_o = alarm_q;
`else
    assign alarm_o = '0;
`endif

    always_comb begin
        reg_data_o = 16'hF001;
        case (reg_addr_i)
            8'h10: reg_data_o = {14'd0, ss_q, ctrl_en_q};
            8'h11: reg_data_o = period_q;
            8'h12: reg_data_o = {13'd0, overrun_q, timeout_q, state_q != S_IDLE};
`ifdef ADC_SCAN_SCHED_ALARM_EN
            8'h19: reg_data_o = {4'd0, thr_q};
            8'h1A: reg_data_o = 16'(alarm_q);
`else
            8'h19: reg_data_o = 16'h0000;
            8'h1A: reg_data_o = 16'h0000;
`endif
            default: begin
                for (int c = 0; c < NCH; c++)
                    if (reg_addr_i == 8'(8'h13 + c)) reg_data_o = {4'd0, avg_q[c*12 +: 12]};
            end
        endcase
    end

    assign avg_data_o  = avg_q;
    assign avg_valid_o = avg_valid_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
// Testbench for adc_scan_sched: register table, directed scan scenarios and a
// randomized run scored against a queue-based averaging model.
module tb_adc_scan_sched;

    localparam int NCH      = 6;
    localparam int AVG_LOG2 = 3;
    localparam int TMO      = 255;
    localparam int NAVG     = 1 << AVG_LOG2;
    localparam int DW       = NCH * 12;
`ifdef ADC_SCAN_SCHED_ALARM_EN
    localparam logic [15:0] THR_RST = 16'h0FFF;
    localparam bit ALARM_ON = 1'b1;
`else
    localparam logic [15:0] THR_RST = 16'h0000;
    localparam bit ALARM_ON = 1'b0;
`endif

    logic           clk_i = 1'b0;
    logic           rst_n_i = 1'b0;
    logic           reg_we_i = 1'b0;
    logic [7:0]     reg_addr_i = 8'h00;
    logic [15:0]    reg_data_i = 16'h0000;
    logic [15:0]    reg_data_o;
    logic           conv_start_o;
    logic           conv_done_i = 1'b0;
    logic [DW-1:0]  adc_data_i = '0;
    logic [DW-1:0]  avg_data_o;
    logic           avg_valid_o;
    logic [NCH-1:0] alarm_o;

    adc_scan_sched #(.NCH(NCH), .AVG_LOG2(AVG_LOG2), .TMO(TMO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
        .reg_data_i(reg_data_i), .reg_data_o(reg_data_o), .conv_start_o(conv_start_o),
        .conv_done_i(conv_done_i), .adc_data_i(adc_data_i), .avg_data_o(avg_data_o),
        .avg_valid_o(avg_valid_o), .alarm_o(alarm_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Sequencer model state and scoreboard
    int            resp_delay = 2;
    int            resp_limit = -1;
    bit            spurious_req = 1'b0;
    bit            dup_req = 1'b0;
    int            pend = 0;
    logic [DW-1:0] sample_src[$];
    logic [DW-1:0] delivered[$];
    int unsigned   start_cyc[$];
    int            n_valid = 0;
    logic [NCH-1:0] exp_alarm = '0;
    logic [11:0]   exp_thr = 12'hFFF;

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [DW-1:0] randSample();
        logic [DW-1:0] s;
        for (int c = 0; c < NCH; c++) s[c*12 +: 12] = 12'($urandom);
        return s;
    endfunction

    // Sequencer: answers each start after resp_delay cycles; can inject stray done pulses.
    initial forever begin
        logic [DW-1:0] s;
        @(negedge clk_i);
        conv_done_i = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                s = (sample_src.size() > 0) ? sample_src.pop_front() : randSample();
                adc_data_i  = s;
                conv_done_i = 1'b1;
                delivered.push_back(s);
            end
        end else if (spurious_req) begin
            spurious_req = 1'b0;
            adc_data_i   = randSample();
            conv_done_i  = 1'b1;
        end
        if (conv_start_o) begin
            if (dup_req) begin
                dup_req     = 1'b0;
                adc_data_i  = randSample();
                conv_done_i = 1'b1;
            end
            if (resp_limit != 0) begin
                pend = resp_delay;
                if (resp_limit > 0) resp_limit--;
            end
        end
    end

    // Scoreboard: every average is the floor mean of the next NAVG delivered samples.
    initial forever begin
        logic [DW-1:0] e, t;
        int unsigned   sum;
        @(negedge clk_i);
        if (conv_start_o) start_cyc.push_back(cyc);
        if (avg_valid_o) begin
            n_valid++;
            if (delivered.size() < NAVG) begin
                expire("sb_underflow");
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    sum = 0;
                    for (int k = 0; k < NAVG; k++) begin
                        t = delivered[k];
                        sum += t[c*12 +: 12];
                    end
                    e[c*12 +: 12] = 12'(sum / NAVG);
                    if (ALARM_ON && e[c*12 +: 12] > exp_thr) exp_alarm[c] = 1'b1;
                end
                for (int k = 0; k < NAVG; k++) void'(delivered.pop_front());
                checkOutput("avg_data", avg_data_o, e);
                checkOutput("alarm_at_valid", DW'(alarm_o), DW'(exp_alarm));
            end
        end
    end

    task automatic writeReg(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk_i);
        reg_we_i = 1'b1; reg_addr_i = a; reg_data_i = d;
        if (ALARM_ON && a == 8'h19) exp_thr = d[11:0];
        if (ALARM_ON && a == 8'h1A) exp_alarm = exp_alarm & ~d[NCH-1:0];
        @(negedge clk_i);
        reg_we_i = 1'b0;
    endtask

    task automatic readReg(input logic [7:0] a, output logic [15:0] d);
        reg_addr_i = a;
        #1 d = reg_data_o;
    endtask

    task automatic checkReg(input string name, input logic [7:0] a, input logic [15:0] exp);
        logic [15:0] d;
        @(negedge clk_i);
        readReg(a, d);
        checkOutput(name, DW'(d), DW'(exp));
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.we) writeReg(v.addr, v.data);
        else      checkReg($sformatf("reg_%02h", v.addr), v.addr, v.exp);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_i);
        #2;
    endtask

    task automatic waitUntilCyc(input int unsigned target);
        while (cyc < target) @(negedge clk_i);
        #2;
    endtask

    task automatic waitValid(input int n0, input int maxc, input string name);
        for (int i = 0; i < maxc && n_valid < n0; i++) begin
            @(negedge clk_i);
            #2;
        end
        if (n_valid < n0) expire(name);
    endtask

    task automatic waitStarts(input int n, input int maxc, input string name);
        for (int i = 0; i < maxc && start_cyc.size() < n; i++) begin
            @(negedge clk_i);
            #2;
        end
        if (start_cyc.size() < n) expire(name);
    endtask

    task automatic waitIdle(input int maxc, input string name);
        logic [15:0] d;
        d = 16'h0001;
        for (int i = 0; i < maxc && d[0]; i++) begin
            @(negedge clk_i);
            readReg(8'h12, d);
        end
        if (d[0]) expire(name);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [DW-1:0] s;
        int v0;
        int unsigned s0;

        // Reset values
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("rst_conv_start", DW'(conv_start_o), '0);
        checkOutput("rst_avg_valid", DW'(avg_valid_o), '0);
        checkOutput("rst_avg_data", avg_data_o, '0);
        checkOutput("rst_alarm", DW'(alarm_o), '0);
        rst_n_i = 1'b1;

        // Register map table
        vecs.push_back('{1'b0, 8'h10, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 8'h11, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 8'h12, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 8'h13, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 8'h18, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 8'h19, 16'h0000, THR_RST});
        vecs.push_back('{1'b0, 8'h1A, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 8'h00, 16'h0000, 16'hF001});
        vecs.push_back('{1'b0, 8'h0F, 16'h0000, 16'hF001});
        vecs.push_back('{1'b0, 8'h1B, 16'h0000, 16'hF001});
        vecs.push_back('{1'b0, 8'hFF, 16'h0000, 16'hF001});
        vecs.push_back('{1'b1, 8'h11, 16'h1234, 16'h0000});
        vecs.push_back('{1'b0, 8'h11, 16'h0000, 16'h1234});
        vecs.push_back('{1'b1, 8'h19, 16'hFABC, 16'h0000});
        vecs.push_back('{1'b0, 8'h19, 16'h0000, ALARM_ON ? 16'h0ABC : 16'h0000});
        vecs.push_back('{1'b1, 8'h19, 16'h0FFF, 16'h0000});
        vecs.push_back('{1'b1, 8'h11, 16'h0000, 16'h0000});
        vecs.push_back('{1'b0, 8'h11, 16'h0000, 16'h0000});
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // PERIOD=4, reply after 2 cycles, ch0 ramps 0x100..0x107
        $display("[TB] periodic scan");
        for (int i = 0; i < NAVG; i++) begin
            s = randSample();
            s[11:0] = 12'h100 + 12'(i);
            sample_src.push_back(s);
        end
        resp_delay = 2; resp_limit = -1;
        start_cyc.delete();
        v0 = n_valid;
        writeReg(8'h11, 16'd4);
        writeReg(8'h10, 16'h0001);
        waitValid(v0 + 1, 200, "periodic_valid");
        writeReg(8'h10, 16'h0000);
        waitIdle(50, "periodic_idle");
        checkOutput("periodic_ch0", DW'(avg_data_o[11:0]), DW'(12'h103));
        checkReg("periodic_reg13", 8'h13, 16'h0103);
        checkOutput("periodic_nvalid", DW'(n_valid - v0), DW'(1));
        checkOutput("periodic_nstart", DW'(start_cyc.size()), DW'(NAVG));
        for (int i = 1; i < NAVG && i < start_cyc.size(); i++)
            checkOutput("periodic_gap", DW'(start_cyc[i] - start_cyc[i-1]), DW'(8));

        // Single-shot, PERIOD=0, full-scale samples
        $display("[TB] single-shot");
        for (int i = 0; i < NAVG; i++) sample_src.push_back({DW{1'b1}});
        resp_delay = 1;
        start_cyc.delete();
        v0 = n_valid;
        writeReg(8'h11, 16'd0);
        writeReg(8'h10, 16'h0002);
        waitValid(v0 + 1, 200, "single_valid");
        checkOutput("single_avg", avg_data_o, {DW{1'b1}});
        waitCycles(3);
        checkReg("single_status", 8'h12, 16'h0000);
        checkReg("single_ctrl", 8'h10, 16'h0000);
        checkOutput("single_nstart", DW'(start_cyc.size()), DW'(NAVG));
        for (int i = 1; i < 4 && i < start_cyc.size(); i++)
            checkOutput("single_gap", DW'(start_cyc[i] - start_cyc[i-1]), DW'(3));

        // Sequencer goes silent after three replies
        $display("[TB] timeout");
        resp_delay = 2; resp_limit = 3;
        start_cyc.delete();
        writeReg(8'h11, 16'd1);
        writeReg(8'h10, 16'h0002);
        waitStarts(4, 100, "tmo_starts");
        s0 = (start_cyc.size() >= 4) ? start_cyc[3] : cyc;
        waitUntilCyc(s0 + TMO - 5);
        readReg(8'h12, reg_data_i);
        checkOutput("tmo_before", DW'(reg_data_i), DW'(16'h0001));
        waitUntilCyc(s0 + TMO + 3);
        checkReg("tmo_after", 8'h12, 16'h0002);
        checkOutput("tmo_nstart", DW'(start_cyc.size()), DW'(4));
        writeReg(8'h12, 16'h0002);
        checkReg("tmo_w1c", 8'h12, 16'h0000);
        delivered.delete();
        resp_limit = -1;

        // Stray done pulses in WAIT and in START
        $display("[TB] overrun");
        start_cyc.delete();
        v0 = n_valid;
        writeReg(8'h11, 16'd20);
        writeReg(8'h10, 16'h0001);
        waitStarts(1, 50, "ovr_start");
        s0 = (start_cyc.size() >= 1) ? start_cyc[0] : cyc;
        waitUntilCyc(s0 + 10);
        spurious_req = 1'b1;
        waitCycles(2);
        checkReg("ovr_wait", 8'h12, 16'h0005);
        writeReg(8'h12, 16'h0004);
        checkReg("ovr_w1c", 8'h12, 16'h0001);
        dup_req = 1'b1;
        waitStarts(2, 50, "ovr_start2");
        waitCycles(2);
        checkReg("ovr_start_cycle", 8'h12, 16'h0005);
        waitValid(v0 + 1, 600, "ovr_valid");
        writeReg(8'h10, 16'h0000);
        waitIdle(50, "ovr_idle");
        delivered.delete();
        writeReg(8'h12, 16'h0004);
        checkReg("ovr_clear", 8'h12, 16'h0000);

        // Threshold alarm on ch3 only
        $display("[TB] alarm");
        for (int i = 0; i < NAVG; i++) begin
            for (int c = 0; c < NCH; c++) s[c*12 +: 12] = (c == 3) ? 12'h801 : 12'h7FF;
            sample_src.push_back(s);
        end
        v0 = n_valid;
        writeReg(8'h19, 16'h0800);
        writeReg(8'h11, 16'd0);
        writeReg(8'h10, 16'h0002);
        waitValid(v0 + 1, 200, "alarm_valid");
        waitCycles(1);
        checkOutput("alarm_out", DW'(alarm_o), ALARM_ON ? DW'(6'b001000) : '0);
        checkReg("alarm_reg", 8'h1A, ALARM_ON ? 16'h0008 : 16'h0000);
        writeReg(8'h1A, 16'h0008);
        #1;
        checkOutput("alarm_w1c", DW'(alarm_o), '0);
        writeReg(8'h19, 16'h0FFF);

        // Randomized continuous scan
        $display("[TB] random scan");
        v0 = n_valid;
        writeReg(8'h19, 16'(12'h600 + 12'($urandom_range(0, 12'h400))));
        for (int r = 0; r < 6; r++) begin
            resp_delay = $urandom_range(1, 5);
            writeReg(8'h11, 16'($urandom_range(0, 6)));
            if (r == 0) writeReg(8'h10, 16'h0001);
            waitValid(v0 + r + 1, 400, "rand_valid");
        end
        writeReg(8'h10, 16'h0000);
        waitIdle(50, "rand_idle");
        delivered.delete();
        checkReg("rand_status", 8'h12, 16'h0000);
        writeReg(8'h1A, 16'h003F);
        writeReg(8'h19, 16'h0FFF);

        // Asynchronous reset in the middle of a conversion
        $display("[TB] reset mid-busy");
        resp_limit = 0;
        start_cyc.delete();
        writeReg(8'h11, 16'd2);
        writeReg(8'h10, 16'h0001);
        waitStarts(1, 50, "rst_start");
        waitCycles(3);
        reg_addr_i = 8'h12;
        rst_n_i = 1'b0;
        #1;
        checkOutput("rstb_conv_start", DW'(conv_start_o), '0);
        checkOutput("rstb_avg_valid", DW'(avg_valid_o), '0);
        checkOutput("rstb_avg_data", avg_data_o, '0);
        checkOutput("rstb_alarm", DW'(alarm_o), '0);
        checkOutput("rstb_status", DW'(reg_data_o), '0);
        exp_alarm = '0;
        exp_thr = 12'hFFF;
        waitCycles(2);
        rst_n_i = 1'b1;
        start_cyc.delete();
        waitCycles(30);
        checkOutput("rstb_nstart", DW'(start_cyc.size()), '0);
        checkReg("rstb_ctrl", 8'h10, 16'h0000);
        checkReg("rstb_thr", 8'h19, THR_RST);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
